// File: rtl/recv_matcher.sv
// recv_matcher: receive-side data finder behind the message-matching CAM.
// Receive requests (each naming a CAM source slot) are queued in FIFO order.
// The head request polls the CAM read port until the slot holds a packet.
// The packet is then offered to the consumer over a valid/ready handshake.
// If MAX_POLLS empty polls go by first, the request is dropped and
// err_timeout pulses.
// All outputs come straight from flops.
module recv_matcher #(
  parameter int packetizer_width = 128,
  parameter int ADDR_WIDTH       = 2,
  parameter int FIFO_DEPTH       = 4,
  parameter int POLL_GAP         = 4,
  parameter int MAX_POLLS        = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_WIDTH-1:0]       req_src,
  output logic                        cam_re,
  output logic [ADDR_WIDTH-1:0]       cam_addr,
  input  logic [packetizer_width-1:0] cam_q,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [packetizer_width-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]       out_src,
  output logic                        err_timeout,
  output logic [ADDR_WIDTH-1:0]       err_src,
  output logic                        busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      MAX_C    = 16'(MAX_POLLS);
  localparam logic [15:0]      GAP_LAST = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;
  localparam bit               POLL_FOREVER = (MAX_POLLS == 0);
  localparam bit               NO_GAP       = (POLL_GAP == 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // Request queue storage and bookkeeping.
  logic [ADDR_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ready_q, ready_d;

  // Sequencer state.
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_src_q, cur_src_d;
  logic [15:0]           poll_cnt_q, poll_cnt_d;
  logic [15:0]           gap_cnt_q, gap_cnt_d;

  // Registered outputs.
  logic                        cam_re_q, cam_re_d;
  logic [ADDR_WIDTH-1:0]       cam_addr_q, cam_addr_d;
  logic                        out_valid_q, out_valid_d;
  logic [packetizer_width-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0]       out_src_q, out_src_d;
  logic                        err_timeout_q, err_timeout_d;
  logic [ADDR_WIDTH-1:0]       err_src_q, err_src_d;
  logic                        busy_q, busy_d;

  // Combinational helpers.
  logic                  push_s;
  logic                  pop_s;
  logic [ADDR_WIDTH-1:0] head_s;
  logic [15:0]           poll_inc_s;
  logic                  cam_hit_s;

  assign push_s     = req_valid && ready_q;
  assign head_s     = mem_q[rd_ptr_q];
  assign cam_hit_s  = (cam_q != '0);
  assign poll_inc_s = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : (poll_cnt_q + 16'd1);

  // Sequencer next state: pop, issue a read, evaluate the result, back off or hold.
  always_comb begin
    state_d       = state_q;
    cur_src_d     = cur_src_q;
    poll_cnt_d    = poll_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    out_data_d    = out_data_q;
    out_src_d     = out_src_q;
    err_timeout_d = 1'b0;
    err_src_d     = err_src_q;
    pop_s         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != {CNT_W{1'b0}}) begin
          pop_s      = 1'b1;
          cur_src_d  = head_s;
          poll_cnt_d = 16'd0;
          state_d    = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cam_hit_s) begin
          out_data_d = cam_q;
          out_src_d  = cur_src_q;
          state_d    = S_HOLD;
        end else begin
          poll_cnt_d = poll_inc_s;
          if (!POLL_FOREVER && (poll_inc_s == MAX_C)) begin
            // Give up on this request; the next one is picked up from IDLE.
            err_timeout_d = 1'b1;
            err_src_d     = cur_src_q;
            state_d       = S_IDLE;
          end else if (NO_GAP) begin
            state_d = S_ISSUE;
          end else begin
            gap_cnt_d = 16'd0;
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_ISSUE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request queue update: push and pop in the same cycle are both honoured.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = req_src;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Output flop inputs, derived from the upcoming state so each output lines up with its state.
  always_comb begin
    cam_re_d    = (state_d == S_ISSUE);
    cam_addr_d  = cam_addr_q;
    if (state_d == S_ISSUE) begin
      cam_addr_d = cur_src_d;
    end else begin
      cam_addr_d = cam_addr_q;
    end
    out_valid_d = (state_d == S_HOLD);
    busy_d      = (state_d != S_IDLE) || (count_d != {CNT_W{1'b0}});
    ready_d     = (count_d != DEPTH_C);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b0;
      state_q       <= S_IDLE;
      cur_src_q     <= '0;
      poll_cnt_q    <= 16'd0;
      gap_cnt_q     <= 16'd0;
      cam_re_q      <= 1'b0;
      cam_addr_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_src_q     <= '0;
      err_timeout_q <= 1'b0;
      err_src_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ready_q       <= ready_d;
      state_q       <= state_d;
      cur_src_q     <= cur_src_d;
      poll_cnt_q    <= poll_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      cam_re_q      <= cam_re_d;
      cam_addr_q    <= cam_addr_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_src_q     <= out_src_d;
      err_timeout_q <= err_timeout_d;
      err_src_q     <= err_src_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready   = ready_q;
  assign cam_re      = cam_re_q;
  assign cam_addr    = cam_addr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_src     = out_src_q;
  assign err_timeout = err_timeout_q;
  assign err_src     = err_src_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_recv_matcher.sv
// Bench for recv_matcher: two instances (A: POLL_GAP=4, MAX_POLLS=4;
// B: POLL_GAP=0, MAX_POLLS=4).
// Each instance has a behavioural CAM with invalidate-on-read.
// A transaction-level reference model tracks pending requests and fetched
// packets.
module tb_recv_matcher;

  localparam int W      = 128;
  localparam int GAP_A  = 4;
  localparam int MAXP_A = 4;
  localparam int GAP_B  = 0;
  localparam int MAXP_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   req_valid, req_ready, cam_re, out_valid, out_ready, err_timeout, busy;
  logic [1:0]   req_src  [2];
  logic [1:0]   cam_addr [2];
  logic [1:0]   out_src  [2];
  logic [1:0]   err_src  [2];
  logic [W-1:0] cam_q    [2];
  logic [W-1:0] out_data [2];

  recv_matcher #(.packetizer_width(W), .ADDR_WIDTH(2), .FIFO_DEPTH(4),
                 .POLL_GAP(GAP_A), .MAX_POLLS(MAXP_A)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_src(req_src[0]),
    .cam_re(cam_re[0]), .cam_addr(cam_addr[0]), .cam_q(cam_q[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_src(out_src[0]), .err_timeout(err_timeout[0]), .err_src(err_src[0]),
    .busy(busy[0]));

  recv_matcher #(.packetizer_width(W), .ADDR_WIDTH(2), .FIFO_DEPTH(4),
                 .POLL_GAP(GAP_B), .MAX_POLLS(MAXP_B)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_src(req_src[1]),
    .cam_re(cam_re[1]), .cam_addr(cam_addr[1]), .cam_q(cam_q[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_src(out_src[1]), .err_timeout(err_timeout[1]), .err_src(err_src[1]),
    .busy(busy[1]));

  logic [W-1:0] cam_mem [2][4];
  logic [W-1:0] rd_data [2];
  logic [1:0]   mq [2][$];   // requests accepted and not yet resolved, oldest first
  logic [W-1:0] pq [2][$];   // packets fetched from the CAM and not yet delivered
  int           polls   [2];
  int           last_re [2];
  int           cyc;
  int           n_assert;
  int           n_fail;

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP_A : GAP_B;
  endfunction

  function automatic int maxp_of(input int i);
    return (i == 0) ? MAXP_A : MAXP_B;
  endfunction

  function automatic logic [W-1:0] rand_pkt();
    return {$urandom(), $urandom(), $urandom(), $urandom()} | 128'd1;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model for one instance, evaluated on the settled values of the current cycle.
  task automatic monitor(input int i);
    logic [1:0] a;
    rd_data[i] = '0;
    if (rst) begin
      mq[i].delete();
      pq[i].delete();
      polls[i] = 0;
      return;
    end
    if (cam_re[i] === 1'b1) begin
      a = cam_addr[i];
      chk($sformatf("no_read_in_hold_%0d", i), out_valid[i], 1'b0);
      chk($sformatf("read_has_request_%0d", i), mq[i].size() != 0, 1'b1);
      if (mq[i].size() != 0) chk($sformatf("cam_addr_%0d", i), a, mq[i][0]);
      if (polls[i] > 0) chk($sformatf("poll_period_%0d", i), cyc - last_re[i], 2 + gap_of(i));
      polls[i]++;
      last_re[i]    = cyc;
      rd_data[i]    = cam_mem[i][a];
      cam_mem[i][a] = '0;
      if (rd_data[i] != '0) pq[i].push_back(rd_data[i]);
    end
    if (out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
      chk($sformatf("delivery_expected_%0d", i), (mq[i].size() != 0) && (pq[i].size() != 0), 1'b1);
      if (mq[i].size() != 0 && pq[i].size() != 0) begin
        chk($sformatf("out_src_%0d", i), out_src[i], mq[i].pop_front());
        chk($sformatf("out_data_%0d", i), out_data[i], pq[i].pop_front());
      end
      polls[i] = 0;
    end
    if (err_timeout[i] === 1'b1) begin
      chk($sformatf("timeout_expected_%0d", i), mq[i].size() != 0, 1'b1);
      if (mq[i].size() != 0) begin
        chk($sformatf("err_src_%0d", i), err_src[i], mq[i].pop_front());
        chk($sformatf("timeout_polls_%0d", i), polls[i], maxp_of(i));
        chk($sformatf("timeout_no_pkt_%0d", i), pq[i].size(), 0);
      end
      polls[i] = 0;
    end
    if (req_valid[i] === 1'b1 && req_ready[i] === 1'b1) mq[i].push_back(req_src[i]);
  endtask

  // Advance one clock; CAM read data becomes visible the cycle after cam_re.
  task automatic step();
    for (int i = 0; i < 2; i++) monitor(i);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) cam_q[i] = rd_data[i];
  endtask

  logic [W-1:0] d1, d2, d4a, d4b, d5, d6;
  logic [W-1:0] d5x [4];
  logic [1:0]   exp_src5 [5];
  logic [W-1:0] exp_dat5 [5];
  int           got;

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    req_valid = 2'b00; out_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_src[i] = 2'd0; cam_q[i] = '0; rd_data[i] = '0; polls[i] = 0; last_re[i] = 0;
      for (int s = 0; s < 4; s++) cam_mem[i][s] = '0;
    end

    // Reset values.
    step(); step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_cam_re", cam_re[i], 1'b0);
      chk("rst_out_valid", out_valid[i], 1'b0);
      chk("rst_err", err_timeout[i], 1'b0);
      chk("rst_busy", busy[i], 1'b0);
      chk("rst_req_ready", req_ready[i], 1'b0);
      chk("rst_cam_addr", cam_addr[i], 2'd0);
      chk("rst_out_data", out_data[i], '0);
      chk("rst_out_src", out_src[i], 2'd0);
      chk("rst_err_src", err_src[i], 2'd0);
    end
    rst = 1'b0;
    step();
    chk("ready_after_rst_a", req_ready[0], 1'b1);
    chk("ready_after_rst_b", req_ready[1], 1'b1);

    // Immediate hit on slot 2.
    d1 = {$urandom(), $urandom(), $urandom(), 32'h000000AB};
    cam_mem[0][2] = d1;
    req_valid[0] = 1'b1; req_src[0] = 2'd2;
    step(); req_valid[0] = 1'b0;
    chk("t1_c1_cam_re", cam_re[0], 1'b0);
    step();
    chk("t1_c2_cam_re", cam_re[0], 1'b1);
    chk("t1_c2_cam_addr", cam_addr[0], 2'd2);
    step();
    chk("t1_c3_cam_re", cam_re[0], 1'b0);
    chk("t1_c3_out_valid", out_valid[0], 1'b0);
    step();
    chk("t1_c4_out_valid", out_valid[0], 1'b1);
    chk("t1_c4_out_data", out_data[0], d1);
    chk("t1_c4_out_src", out_src[0], 2'd2);
    step();
    chk("t1_c5_out_valid", out_valid[0], 1'b0);
    chk("t1_c5_busy", busy[0], 1'b0);

    // Miss three times, then hit on the fourth poll (MAX_POLLS boundary).
    d2 = rand_pkt();
    req_valid[0] = 1'b1; req_src[0] = 2'd1;
    step(); req_valid[0] = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      chk($sformatf("t2_cam_re_c%0d", c), cam_re[0], (c == 2 || c == 8 || c == 14 || c == 20));
      chk($sformatf("t2_err_c%0d", c), err_timeout[0], 1'b0);
      chk($sformatf("t2_out_valid_c%0d", c), out_valid[0], (c == 22));
      if (c == 22) chk("t2_out_data", out_data[0], d2);
      if (c == 15) cam_mem[0][1] = d2;
      step();
    end
    chk("t2_busy_end", busy[0], 1'b0);

    // Timeout on instance B, slot 3 permanently empty.
    req_valid[1] = 1'b1; req_src[1] = 2'd3;
    step(); req_valid[1] = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("t3_cam_re_c%0d", c), cam_re[1], (c == 2 || c == 4 || c == 6 || c == 8));
      chk($sformatf("t3_err_c%0d", c), err_timeout[1], (c == 10));
      chk($sformatf("t3_out_valid_c%0d", c), out_valid[1], 1'b0);
      chk($sformatf("t3_busy_c%0d", c), busy[1], (c < 10));
      if (c >= 10) chk($sformatf("t3_err_src_c%0d", c), err_src[1], 2'd3);
      step();
    end

    // Backpressure with a second request queued behind.
    d4a = rand_pkt(); d4b = rand_pkt();
    cam_mem[0][0] = d4a; cam_mem[0][3] = d4b;
    out_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_src[0] = 2'd0;
    step(); req_src[0] = 2'd3;
    step(); req_valid[0] = 1'b0;
    chk("t4_c2_cam_addr", cam_addr[0], 2'd0);
    step(); step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_hold_valid_%0d", k), out_valid[0], 1'b1);
      chk($sformatf("t4_hold_data_%0d", k), out_data[0], d4a);
      chk($sformatf("t4_hold_src_%0d", k), out_src[0], 2'd0);
      chk($sformatf("t4_hold_cam_re_%0d", k), cam_re[0], 1'b0);
      step();
    end
    out_ready[0] = 1'b1;
    chk("t4_c9_valid", out_valid[0], 1'b1);
    step();
    chk("t4_c10_valid", out_valid[0], 1'b0);
    chk("t4_c10_cam_re", cam_re[0], 1'b0);
    step();
    chk("t4_c11_cam_re", cam_re[0], 1'b1);
    chk("t4_c11_cam_addr", cam_addr[0], 2'd3);
    step(); step();
    chk("t4_c13_valid", out_valid[0], 1'b1);
    chk("t4_c13_data", out_data[0], d4b);
    chk("t4_c13_src", out_src[0], 2'd3);
    step();

    // Queue full while the sequencer sits in HOLD.
    d5 = rand_pkt();
    cam_mem[0][2] = d5;
    out_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_src[0] = 2'd2;
    step(); req_valid[0] = 1'b0;
    step(); step(); step();
    chk("t5_in_hold", out_valid[0], 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_ready_before_push%0d", k), req_ready[0], 1'b1);
      req_valid[0] = 1'b1; req_src[0] = 2'(k);
      step();
    end
    req_src[0] = 2'd1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t5_full_%0d", k), req_ready[0], 1'b0);
      step();
    end
    req_valid[0] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      d5x[s] = rand_pkt();
      cam_mem[0][s] = d5x[s];
    end
    exp_src5[0] = 2'd2; exp_dat5[0] = d5;
    for (int s = 0; s < 4; s++) begin
      exp_src5[s + 1] = 2'(s); exp_dat5[s + 1] = d5x[s];
    end
    out_ready[0] = 1'b1;
    got = 0;
    for (int t = 0; t < 200; t++) begin
      if (out_valid[0] === 1'b1 && got < 5) begin
        chk($sformatf("t5_order_src_%0d", got), out_src[0], exp_src5[got]);
        chk($sformatf("t5_order_data_%0d", got), out_data[0], exp_dat5[got]);
        got++;
      end
      if (got == 5 && busy[0] === 1'b0) break;
      step();
    end
    chk("t5_delivered", got, 5);
    chk("t5_busy_end", busy[0], 1'b0);

    // Reset while waiting on CAM data.
    d6 = rand_pkt();
    cam_mem[0][1] = d6;
    req_valid[0] = 1'b1; req_src[0] = 2'd1;
    step(); req_valid[0] = 1'b0;
    step();
    chk("t6_c2_cam_re", cam_re[0], 1'b1);
    step();
    rst = 1'b1;
    step();
    chk("t6_rst_cam_re", cam_re[0], 1'b0);
    chk("t6_rst_out_valid", out_valid[0], 1'b0);
    chk("t6_rst_out_data", out_data[0], '0);
    chk("t6_rst_busy", busy[0], 1'b0);
    chk("t6_rst_ready", req_ready[0], 1'b0);
    chk("t6_rst_cam_addr", cam_addr[0], 2'd0);
    chk("t6_rst_err_src_b", err_src[1], 2'd0);
    rst = 1'b0;
    step();
    chk("t6_rel_ready", req_ready[0], 1'b1);
    chk("t6_rel_busy", busy[0], 1'b0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t6_no_out_%0d", k), out_valid[0], 1'b0);
      chk($sformatf("t6_no_read_%0d", k), cam_re[0], 1'b0);
      step();
    end

    // Randomized traffic on both instances, checked by the reference model.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 2; i++) begin
        req_valid[i] = ($urandom_range(0, 3) == 0);
        req_src[i]   = 2'($urandom_range(0, 3));
        out_ready[i] = 1'($urandom_range(0, 1));
        for (int s = 0; s < 4; s++) begin
          if (cam_mem[i][s] == '0 && $urandom_range(0, 9) == 0) cam_mem[i][s] = rand_pkt();
        end
      end
      step();
    end
    req_valid = 2'b00; out_ready = 2'b11;
    for (int t = 0; t < 600; t++) begin
      if (busy === 2'b00) break;
      step();
    end
    step();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("drain_busy_%0d", i), busy[i], 1'b0);
      chk($sformatf("drain_requests_%0d", i), mq[i].size(), 0);
      chk($sformatf("drain_packets_%0d", i), pq[i].size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/recv_matcher.md
Name: recv_matcher

Overview:
- Receive-side data finder that sits directly downstream of the message-matching CAM's read port.
- Queues MPI receive requests, each naming a source slot.
- Polls the CAM read port for that slot until a packet is present, then hands the packet to the receive consumer over a valid/ready handshake.
- Abandons a request with an error pulse after a bounded number of empty polls.

Parameters:
- packetizer_width, 128, packet width returned by the CAM read port.
- ADDR_WIDTH, 2, CAM slot address width (source index).
- FIFO_DEPTH, 4, request queue depth (power of two, >=2).
- POLL_GAP, 4, idle cycles between consecutive polls after a miss (0 allowed).
- MAX_POLLS, 256, polls before timeout; 0 = poll forever; max 65535.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset; synchronous, active-high.
- req_valid, in, 1, receive request valid.
- req_ready, out, 1, request queue not full.
- req_src, in, ADDR_WIDTH, CAM slot to match.
- cam_re, out, 1, CAM port-B read enable.
- cam_addr, out, ADDR_WIDTH, CAM port-B address.
- cam_q, in, packetizer_width, CAM port-B data. Valid the cycle after cam_re. All-zero = no data.
- out_valid, out, 1, matched packet valid.
- out_ready, in, 1, consumer accepts packet.
- out_data, out, packetizer_width, matched packet.
- out_src, out, ADDR_WIDTH, slot the packet came from.
- err_timeout, out, 1, one-cycle pulse when a request is dropped.
- err_src, out, ADDR_WIDTH, slot of the dropped request; held until the next timeout.
- busy, out, 1, FSM not IDLE or queue non-empty.

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- While rst is high:
  - queue emptied; FSM to IDLE; counters 0.
  - cam_re, out_valid, err_timeout, busy = 0.
  - cam_addr, out_data, out_src, err_src = 0.
  - req_ready = 0.
- req_ready = !full, starting the cycle after rst deasserts.
- Push on req_valid && req_ready. req_valid while full is ignored; the requester must hold the request.
- Requests are serviced strictly in FIFO order. Only one request is outstanding at the CAM at a time.
- FSM states: IDLE, ISSUE, WAIT, GAP, HOLD.
  - IDLE: if queue non-empty, pop into cur_src, clear poll_cnt, go to ISSUE. Push and pop in the same cycle are both honoured.
  - ISSUE: cam_re=1 and cam_addr=cur_src for exactly this one cycle; go to WAIT. cam_re is 0 in every other state. cam_addr holds its last value.
  - WAIT: sample cam_q.
    - Hit (cam_q != 0): latch out_data=cam_q and out_src=cur_src; go to HOLD.
    - Miss: poll_cnt+1. If MAX_POLLS != 0 and the new poll_cnt == MAX_POLLS, pulse err_timeout, set err_src=cur_src, go to IDLE. Otherwise go to GAP, or directly to ISSUE if POLL_GAP==0.
  - GAP: count POLL_GAP cycles, then go to ISSUE.
  - HOLD: out_valid=1; out_data and out_src stable. On out_ready, go to IDLE with out_valid=0 the next cycle. No CAM reads are issued while in HOLD.
- Latency on an immediate hit (request accepted in cycle 0, queue empty, FSM IDLE):
  - cycle 1: pop.
  - cycle 2: cam_re.
  - cycle 3: WAIT.
  - cycle 4: out_valid.
- Poll period after a miss: 2+POLL_GAP cycles between cam_re pulses.
- The CAM invalidates the slot on a hit read, so a packet is never delivered twice. The module must never assert cam_re while in HOLD.
- poll_cnt is 16 bits and saturates. It is not compared when MAX_POLLS==0.
- A queue of identical req_src values is legal; each request consumes one packet.
- Reset mid-operation (any state): immediate return to reset values. cam_re deasserts in the cycle after rst is sampled. A packet already consumed from the CAM in WAIT is discarded; the CAM is reset in the same domain.
- No combinational paths from inputs to outputs, except req_ready, which depends only on state.

Test Plan:
- Immediate hit: rst 2 cycles. req_src=2 in cycle 0; cam model returns 0x...AB for slot 2. Expect cam_re/cam_addr=2 in cycle 2, out_valid with out_data=0x...AB and out_src=2 in cycle 4. With out_ready=1, out_valid drops in cycle 5. busy low afterwards.
- Miss then hit: POLL_GAP=4, slot 1 empty for 3 polls, then filled. Expect cam_re at cycles 2, 8, 14, 20 (period 6) and out_valid in cycle 22. err_timeout never asserted.
- Timeout: MAX_POLLS=4, POLL_GAP=0, slot 3 permanently empty. Expect 4 cam_re pulses 2 cycles apart, then err_timeout 1 cycle with err_src=3, FSM IDLE, no out_valid.
- Backpressure: hit with out_ready=0 for 5 cycles. Expect out_valid, out_data, out_src stable; cam_re=0 throughout HOLD; queued second request starts ISSUE 2 cycles after the handshake.
- Queue full: hold the FSM in HOLD; push 4 requests (src 0,1,2,3). req_ready falls after the 4th push; the 5th req_valid is not accepted. Outputs are later delivered in order 0,1,2,3.
- Reset mid-WAIT: assert rst in the WAIT cycle. Next cycle all outputs are 0 and req_ready=0; one cycle after release, req_ready=1 and the queue is empty.
